// File: rtl/mux.sv
// Parameterised N:1 bus multiplexer.
// Output is combinational or registered, chosen by OUTPUT_REG.
module mux #(
  parameter int BITS_ENABLES = 1,
  parameter int BUS_SIZE     = 32,
  parameter int OUTPUT_REG   = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [BITS_ENABLES-1:0]                i_en,
  input  logic [(2**BITS_ENABLES)*BUS_SIZE-1:0]  i_data,
  output logic [BUS_SIZE-1:0]                    o_data
);

  localparam int N = 2 ** BITS_ENABLES;

  logic [BUS_SIZE-1:0] sel;

  // One compare per input keeps every select value explicitly decoded.
  always_comb begin
    sel = '0;
    for (int k = 0; k < N; k++) begin
      if (i_en == BITS_ENABLES'(k)) begin
        sel = i_data[k*BUS_SIZE +: BUS_SIZE];
      end
    end
  end

  if (OUTPUT_REG != 0) begin : g_reg
    always_ff @(posedge clk) begin
      if (rst) begin
        o_data <= '0;
      end else begin
        o_data <= sel;
      end
    end
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst};
    assign o_data = sel;
  end

endmodule

// File: tb/tb_mux.sv
// Self-checking bench for mux.
// Covers combinational and registered configurations.
module tb_mux;

  logic clk;
  logic rst;

  logic        en_c0;
  logic [63:0] d_c0;
  logic [31:0] o_c0;

  logic [1:0]  en_c1;
  logic [31:0] d_c1;
  logic [7:0]  o_c1;

  logic        en_r0;
  logic [63:0] d_r0;
  logic [31:0] o_r0;

  logic [2:0]  en_r1;
  logic [39:0] d_r1;
  logic [4:0]  o_r1;

  int errors;
  int checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux u_c0 (
    .clk(clk), .rst(rst), .i_en(en_c0),
    .i_data(d_c0), .o_data(o_c0)
  );

  mux #(.BITS_ENABLES(2), .BUS_SIZE(8)) u_c1 (
    .clk(clk), .rst(rst), .i_en(en_c1),
    .i_data(d_c1), .o_data(o_c1)
  );

  mux #(.OUTPUT_REG(1)) u_r0 (
    .clk(clk), .rst(rst), .i_en(en_r0),
    .i_data(d_r0), .o_data(o_r0)
  );

  mux #(.BITS_ENABLES(3), .BUS_SIZE(5),
        .OUTPUT_REG(1)) u_r1 (
    .clk(clk), .rst(rst), .i_en(en_r1),
    .i_data(d_r1), .o_data(o_r1)
  );

  // Reference: shift the packed vector down to word sel, mask w bits.
  function automatic logic [31:0] ref_slice(
    input logic [63:0] d, input int sel, input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return 32'((d >> (sel * w)) & mask);
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    en_r0 = 1'b1;
    d_r0 = {32'h12345678, 32'h9};
    en_r1 = 3'd7;
    d_r1 = '1;
    @(posedge clk); #1;
    checks++;
    if (o_r0 !== 32'h0) begin
      errors++;
      $display("FAIL reset_r0 got=%h exp=%h", o_r0, 32'h0);
    end
    checks++;
    if (o_r1 !== 5'h0) begin
      errors++;
      $display("FAIL reset_r1 got=%h exp=%h", o_r1, 5'h0);
    end
  endtask

  task automatic test_comb_default();
    d_c0 = {32'hDEADBEEF, 32'h00000005};
    en_c0 = 1'b0;
    #1;
    checks++;
    if (o_c0 !== 32'h00000005) begin
      errors++;
      $display("FAIL comb_en0 got=%h exp=%h", o_c0, 32'h5);
    end
    en_c0 = 1'b1;
    #1;
    checks++;
    if (o_c0 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL comb_en1 got=%h exp=%h", o_c0, 32'hDEADBEEF);
    end
  endtask

  task automatic test_comb_reset_ignored();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (o_c0 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL comb_rst_hi got=%h exp=%h", o_c0, 32'hDEADBEEF);
    end
    @(posedge clk); #1;
    checks++;
    if (o_c0 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL comb_rst_edge got=%h exp=%h", o_c0, 32'hDEADBEEF);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_comb_4way();
    logic [7:0] exp [4];
    exp[0] = 8'h11; exp[1] = 8'h22;
    exp[2] = 8'h33; exp[3] = 8'h44;
    d_c1 = 32'h44332211;
    for (int i = 0; i < 4; i++) begin
      en_c1 = 2'(i);
      #1;
      checks++;
      if (o_c1 !== exp[i]) begin
        errors++;
        $display("FAIL comb4_en%0d got=%h exp=%h", i, o_c1, exp[i]);
      end
    end
  endtask

  task automatic test_reg_basic();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (o_r0 !== 32'h0) begin
      errors++;
      $display("FAIL reg_rst got=%h exp=%h", o_r0, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    en_r0 = 1'b1;
    d_r0 = {32'hA5A5A5A5, 32'h1};
    #1;
    checks++;
    if (o_r0 !== 32'h0) begin
      errors++;
      $display("FAIL reg_pre_edge got=%h exp=%h", o_r0, 32'h0);
    end
    @(posedge clk); #1;
    checks++;
    if (o_r0 !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL reg_post_edge got=%h exp=%h", o_r0, 32'hA5A5A5A5);
    end
    @(negedge clk);
    en_r0 = 1'b0;
    #1;
    checks++;
    if (o_r0 !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL reg_hold got=%h exp=%h", o_r0, 32'hA5A5A5A5);
    end
    @(posedge clk); #1;
    checks++;
    if (o_r0 !== 32'h1) begin
      errors++;
      $display("FAIL reg_lsb got=%h exp=%h", o_r0, 32'h1);
    end
    @(negedge clk);
    en_r0 = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reg_mid_reset();
    checks++;
    if (o_r0 !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL mid_start got=%h exp=%h", o_r0, 32'hA5A5A5A5);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (o_r0 !== 32'h0) begin
      errors++;
      $display("FAIL mid_rst got=%h exp=%h", o_r0, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (o_r0 !== 32'h0) begin
      errors++;
      $display("FAIL mid_pre got=%h exp=%h", o_r0, 32'h0);
    end
    @(posedge clk); #1;
    checks++;
    if (o_r0 !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL mid_restore got=%h exp=%h", o_r0, 32'hA5A5A5A5);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_r0;
    logic [31:0] exp_r1;
    logic [31:0] exp_c;
    logic [63:0] r;
    @(negedge clk);
    rst = 1'b0;
    en_r0 = 1'($urandom);
    d_r0 = {$urandom, $urandom};
    en_r1 = 3'($urandom);
    d_r1 = 40'({$urandom, $urandom});
    exp_r0 = ref_slice(d_r0, int'(en_r0), 32);
    exp_r1 = ref_slice(64'(d_r1), int'(en_r1), 5);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      checks++;
      if (o_r0 !== exp_r0) begin
        errors++;
        $display("FAIL rnd_r0 #%0d got=%h exp=%h", i, o_r0, exp_r0);
      end
      checks++;
      if (o_r1 !== exp_r1[4:0]) begin
        errors++;
        $display("FAIL rnd_r1 #%0d got=%h exp=%h", i, o_r1, exp_r1[4:0]);
      end
      rst = ($urandom_range(15) == 0);
      en_r0 = 1'($urandom);
      d_r0 = {$urandom, $urandom};
      en_r1 = 3'($urandom);
      d_r1 = 40'({$urandom, $urandom});
      exp_r0 = rst ? 32'h0 : ref_slice(d_r0, int'(en_r0), 32);
      exp_r1 = rst ? 32'h0 : ref_slice(64'(d_r1), int'(en_r1), 5);
      en_c0 = 1'($urandom);
      d_c0 = {$urandom, $urandom};
      en_c1 = 2'($urandom);
      d_c1 = $urandom;
      #1;
      exp_c = ref_slice(d_c0, int'(en_c0), 32);
      checks++;
      if (o_c0 !== exp_c) begin
        errors++;
        $display("FAIL rnd_c0 #%0d got=%h exp=%h", i, o_c0, exp_c);
      end
      r = 64'(d_c1);
      exp_c = ref_slice(r, int'(en_c1), 8);
      checks++;
      if (o_c1 !== exp_c[7:0]) begin
        errors++;
        $display("FAIL rnd_c1 #%0d got=%h exp=%h", i, o_c1, exp_c[7:0]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    en_c0 = 1'b0; d_c0 = '0;
    en_c1 = '0;   d_c1 = '0;
    en_r0 = 1'b0; d_r0 = '0;
    en_r1 = '0;   d_r1 = '0;
    test_reset();
    test_comb_default();
    test_comb_reset_ignored();
    test_comb_4way();
    test_reg_basic();
    test_reg_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux.md
MUX -- requirements
Module: mux

Interface
REQ-001 Parameter BITS_ENABLES, default 1: select width. Number of inputs N SHALL be 2**BITS_ENABLES, with BITS_ENABLES >= 1.
REQ-002 Parameter BUS_SIZE, default 32: width of each data input and of the output, with BUS_SIZE >= 1.
REQ-003 Parameter OUTPUT_REG, default 0: 0 means purely combinational output; 1 means registered output.
REQ-004 clk  input  1  system clock; rising-edge active; used only when OUTPUT_REG=1.
REQ-005 rst  input  1  reset, synchronous and active-high; used only when OUTPUT_REG=1.
REQ-006 i_en  input  BITS_ENABLES  select index, unsigned.
REQ-007 i_data  input  N*BUS_SIZE  packed inputs; input k occupies bits [k*BUS_SIZE +: BUS_SIZE], so input 0 is the LSB slice.
REQ-008 o_data  output  BUS_SIZE  selected data.

Function
REQ-009 With OUTPUT_REG=0, o_data SHALL equal slice i_en of i_data combinationally, with zero latency.
REQ-010 With OUTPUT_REG=0, clk and rst SHALL have no effect on o_data.
REQ-011 With OUTPUT_REG=1, o_data SHALL update on each rising clk edge to slice i_en of i_data sampled at that edge, giving 1-cycle latency.
REQ-012 Every i_en value in 0..N-1 is legal; no out-of-range condition exists.
REQ-013 i_en = N-1 SHALL select the MSB slice [N*BUS_SIZE-1 : (N-1)*BUS_SIZE].
REQ-014 No bits SHALL be added, dropped, sign-extended or reordered; the output is a bit-exact copy of the selected slice.
REQ-015 Simultaneous changes of i_en and i_data SHALL yield the slice indexed by the new i_en of the new i_data: immediately when OUTPUT_REG=0, at the next edge when OUTPUT_REG=1.
REQ-016 The select path SHALL be free of latches, with all select values fully decoded.
REQ-017 Instantiation with BITS_ENABLES=1 and BUS_SIZE=32 SHALL behave as a 2:1 32-bit mux: i_en=0 selects the lower word, i_en=1 selects the upper word.

Reset
REQ-018 With OUTPUT_REG=1, rst=1 at a rising clk edge SHALL force o_data to all-zeros, overriding data capture.
REQ-019 With OUTPUT_REG=1, the first edge after rst deasserts SHALL capture the selected slice normally.
REQ-020 With OUTPUT_REG=0, there SHALL be no reset state; o_data reflects inputs at all times, including while rst=1.

Structure
REQ-021 No shared package is required; N and the slice arithmetic SHALL be local parameters derived inside the module.
REQ-022 The block SHALL be one module: a combinational selection stage, followed by an optional output register stage chosen by OUTPUT_REG via a generate branch; no sub-module.
REQ-023 The block SHALL contain no other state, FSM or handshake.

Verification
REQ-024 Defaults, i_data={32'hDEADBEEF, 32'h00000005}: i_en=0 -> o_data=32'h00000005 immediately; i_en=1 -> o_data=32'hDEADBEEF immediately.
REQ-025 Defaults, toggle rst=1 with i_en=1 -> o_data stays 32'hDEADBEEF, unaffected by reset.
REQ-026 BITS_ENABLES=2, BUS_SIZE=8, i_data=32'h44332211: i_en=0,1,2,3 -> o_data=8'h11, 8'h22, 8'h33, 8'h44.
REQ-027 OUTPUT_REG=1, rst=1 for one edge -> o_data=0; then i_en=1, i_data={32'hA5A5A5A5, 32'h1} -> o_data=32'hA5A5A5A5 after exactly one edge, unchanged before it.
REQ-028 OUTPUT_REG=1, assert rst mid-stream while o_data=32'hA5A5A5A5 -> o_data=0 at that edge; deassert -> next edge restores the selected value.
REQ-029 Randomized: 1000 random i_en/i_data vectors per configuration compared against a reference slice model, with zero mismatches.
